// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator: issues one fetch at a time, presents the returned
// instruction to ID, predicts the next PC from the IF mini-decoder, and follows EX redirects.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module if_pc_gen #(
  parameter logic [`XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // fetch request / response
  output logic                    ifu_req_valid_o,
  input  logic                    ifu_req_ready_i,
  output logic [`XLEN-1:0]        ifu_req_addr_o,
  input  logic                    ifu_rsp_valid_i,
  input  logic [`INSTR_WIDTH-1:0] ifu_rsp_instr_i,
  // IF mini-decoder
  output logic [`INSTR_WIDTH-1:0] mini_instr_o,
  input  logic                    mini_dec_jal_i,
  input  logic                    mini_dec_jalr_i,
  input  logic                    mini_dec_branch_i,
  input  logic [4:0]              mini_dec_rs1_idx_i,
  input  logic [`XLEN-1:0]        mini_dec_imm_i,
  // IF -> ID
  output logic                    if_valid_o,
  input  logic                    if_ready_i,
  output logic [`XLEN-1:0]        if_pc_o,
  output logic [`INSTR_WIDTH-1:0] if_instr_o,
  output logic                    if_pred_taken_o,
  // EX redirect
  input  logic                    ex_flush_i,
  input  logic [`XLEN-1:0]        ex_flush_pc_i
);

  typedef enum logic [1:0] {
    S_REQ,
    S_RSP,
    S_HOLD,
    S_JWAIT
  } state_e;

  state_e                  state_q, state_d;
  logic [`XLEN-1:0]        pc_q, pc_d;
  logic                    drop_q, drop_d;
  logic [`INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;

  logic [`XLEN-1:0]        next_pc;
  logic                    pred_taken;
  logic                    jalr_wait;
  logic                    rsp_fire;
  logic                    present;

  // Static prediction from the mini-decoder flags of the instruction on mini_instr_o
  always_comb begin
    next_pc    = pc_q + `XLEN'(4);
    pred_taken = 1'b0;
    jalr_wait  = 1'b0;
    if (mini_dec_jal_i) begin
      next_pc    = pc_q + mini_dec_imm_i;
      pred_taken = 1'b1;
    end else if (mini_dec_branch_i && mini_dec_imm_i[`XLEN-1]) begin
      next_pc    = pc_q + mini_dec_imm_i;
      pred_taken = 1'b1;
    end else if (mini_dec_jalr_i) begin
      if (mini_dec_rs1_idx_i == 5'd0) begin
        next_pc    = mini_dec_imm_i & ~`XLEN'(1);
        pred_taken = 1'b1;
      end else begin
        jalr_wait  = 1'b1;
      end
    end
  end

  assign rsp_fire = (state_q == S_RSP) && ifu_rsp_valid_i;
  assign present  = (rsp_fire && !drop_q) || (state_q == S_HOLD);

  assign mini_instr_o    = (state_q == S_HOLD) ? hold_instr_q : ifu_rsp_instr_i;
  assign ifu_req_valid_o = rst_n && (state_q == S_REQ);
  assign ifu_req_addr_o  = pc_q;
  assign if_valid_o      = rst_n && present && !ex_flush_i;
  assign if_pc_o         = pc_q;
  assign if_instr_o      = mini_instr_o;
  assign if_pred_taken_o = if_valid_o && pred_taken;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    hold_instr_d = hold_instr_q;

    if (ex_flush_i) begin
      // A request already handed to memory (or handed over this cycle) still owes a
      // response; stay in RSP with the drop flag so that response is swallowed.
      pc_d = ex_flush_pc_i;
      unique case (state_q)
        S_REQ: begin
          if (ifu_req_ready_i) begin
            state_d = S_RSP;
            drop_d  = 1'b1;
          end
        end
        S_RSP: begin
          if (ifu_rsp_valid_i) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (ifu_req_ready_i) state_d = S_RSP;
        end
        S_RSP: begin
          if (ifu_rsp_valid_i) begin
            if (drop_q) begin
              state_d = S_REQ;
              drop_d  = 1'b0;
            end else if (!if_ready_i) begin
              state_d      = S_HOLD;
              hold_instr_d = ifu_rsp_instr_i;
            end
          end
        end
        S_HOLD: ;
        S_JWAIT: ;
        default: state_d = S_REQ;
      endcase

      if (present && if_ready_i) begin
        if (jalr_wait) begin
          state_d = S_JWAIT;
        end else begin
          state_d = S_REQ;
          pc_d    = next_pc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      hold_instr_q <= hold_instr_d;
    end
  end

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed bench for if_pc_gen: the bench plays memory and mini-decoder, with
// hand-computed addresses, PCs and predictions.
module tb_if_pc_gen;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0010_0093;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid_o;
  logic        ifu_req_ready_i;
  logic [31:0] ifu_req_addr_o;
  logic        ifu_rsp_valid_i;
  logic [31:0] ifu_rsp_instr_i;
  logic [31:0] mini_instr_o;
  logic        mini_dec_jal_i;
  logic        mini_dec_jalr_i;
  logic        mini_dec_branch_i;
  logic [4:0]  mini_dec_rs1_idx_i;
  logic [31:0] mini_dec_imm_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_pred_taken_o;
  logic        ex_flush_i;
  logic [31:0] ex_flush_pc_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  if_pc_gen #(.RESET_PC(32'h8000_0000)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ifu_req_valid_o    (ifu_req_valid_o),
    .ifu_req_ready_i    (ifu_req_ready_i),
    .ifu_req_addr_o     (ifu_req_addr_o),
    .ifu_rsp_valid_i    (ifu_rsp_valid_i),
    .ifu_rsp_instr_i    (ifu_rsp_instr_i),
    .mini_instr_o       (mini_instr_o),
    .mini_dec_jal_i     (mini_dec_jal_i),
    .mini_dec_jalr_i    (mini_dec_jalr_i),
    .mini_dec_branch_i  (mini_dec_branch_i),
    .mini_dec_rs1_idx_i (mini_dec_rs1_idx_i),
    .mini_dec_imm_i     (mini_dec_imm_i),
    .if_valid_o         (if_valid_o),
    .if_ready_i         (if_ready_i),
    .if_pc_o            (if_pc_o),
    .if_instr_o         (if_instr_o),
    .if_pred_taken_o    (if_pred_taken_o),
    .ex_flush_i         (ex_flush_i),
    .ex_flush_pc_i      (ex_flush_pc_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_ready_i    = 1'b0;
    ifu_rsp_valid_i    = 1'b0;
    ifu_rsp_instr_i    = 32'hDEAD_BEEF;
    mini_dec_jal_i     = 1'b0;
    mini_dec_jalr_i    = 1'b0;
    mini_dec_branch_i  = 1'b0;
    mini_dec_rs1_idx_i = 5'd0;
    mini_dec_imm_i     = '0;
    if_ready_i         = 1'b0;
    ex_flush_i         = 1'b0;
    ex_flush_pc_i      = '0;
  endtask

  // Memory accepts the pending request; checks the address it was asked for.
  task automatic fetch(input string tag, input logic [31:0] exp_addr);
    #1;
    check({tag, ".req_valid"}, 32'(ifu_req_valid_o), 32'd1);
    check({tag, ".req_addr"}, ifu_req_addr_o, exp_addr);
    check({tag, ".if_valid"}, 32'(if_valid_o), 32'd0);
    ifu_req_ready_i = 1'b1;
    next_cycle();
    clear_inputs();
  endtask

  // Memory returns an instruction and ID takes it in the same cycle.
  task automatic respond(input string tag, input logic [31:0] instr, input logic jal,
                         input logic jalr, input logic br, input logic [4:0] rs1,
                         input logic [31:0] imm, input logic [31:0] exp_pc,
                         input logic exp_pred);
    ifu_rsp_valid_i    = 1'b1;
    ifu_rsp_instr_i    = instr;
    mini_dec_jal_i     = jal;
    mini_dec_jalr_i    = jalr;
    mini_dec_branch_i  = br;
    mini_dec_rs1_idx_i = rs1;
    mini_dec_imm_i     = imm;
    if_ready_i         = 1'b1;
    #1;
    check({tag, ".if_valid"}, 32'(if_valid_o), 32'd1);
    check({tag, ".if_pc"}, if_pc_o, exp_pc);
    check({tag, ".if_instr"}, if_instr_o, instr);
    check({tag, ".pred"}, 32'(if_pred_taken_o), 32'(exp_pred));
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) next_cycle();
    check("rst.req_valid", 32'(ifu_req_valid_o), 32'd0);
    check("rst.if_valid", 32'(if_valid_o), 32'd0);
    check("rst.pred", 32'(if_pred_taken_o), 32'd0);
    check("rst.addr", ifu_req_addr_o, 32'h8000_0000);
    #2 rst_n = 1'b1;
    #1;
    check("post_rst.req_valid", 32'(ifu_req_valid_o), 32'd1);
    check("post_rst.addr", ifu_req_addr_o, 32'h8000_0000);
    next_cycle();

    // Sequential nops, then jal -16 back to the start
    fetch("seq0", 32'h8000_0000); respond("seq0", NOP, 0, 0, 0, 0, 0, 32'h8000_0000, 0);
    fetch("seq1", 32'h8000_0004); respond("seq1", NOP, 0, 0, 0, 0, 0, 32'h8000_0004, 0);
    fetch("seq2", 32'h8000_0008); respond("seq2", NOP, 0, 0, 0, 0, 0, 32'h8000_0008, 0);
    fetch("seq3", 32'h8000_000C); respond("seq3", NOP, 0, 0, 0, 0, 0, 32'h8000_000C, 0);
    fetch("jal", 32'h8000_0010);
    respond("jal", 32'hFF1F_F06F, 1, 0, 0, 0, 32'hFFFF_FFF0, 32'h8000_0010, 1);

    // Forward branch not taken; backward branch taken across 0x80000000
    fetch("bfwd", 32'h8000_0000);
    respond("bfwd", 32'h0000_0463, 0, 0, 1, 0, 32'h0000_0008, 32'h8000_0000, 0);
    fetch("jal2", 32'h8000_0004);
    respond("jal2", 32'hFFDF_F06F, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h8000_0004, 1);
    fetch("bbwd", 32'h8000_0000);
    respond("bbwd", 32'hFE00_0EE3, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h8000_0000, 1);

    // jalr x0: target is imm with bit 0 cleared
    fetch("jalr0", 32'h7FFF_FFFC);
    respond("jalr0", 32'h0000_0067, 0, 1, 0, 5'd0, 32'h8000_0101, 32'h7FFF_FFFC, 1);

    // jalr x5: wait for EX
    fetch("jalr5", 32'h8000_0100);
    respond("jalr5", 32'h0002_8067, 0, 1, 0, 5'd5, 32'h0, 32'h8000_0100, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      check("jwait.req_valid", 32'(ifu_req_valid_o), 32'd0);
      check("jwait.if_valid", 32'(if_valid_o), 32'd0);
      next_cycle();
    end
    ex_flush_i = 1'b1; ex_flush_pc_i = 32'h8000_0100;
    #1;
    check("jwait_flush.if_valid", 32'(if_valid_o), 32'd0);
    next_cycle();
    clear_inputs();

    // ID stalls for 3 cycles: hold register keeps pc/instr stable, no new request
    fetch("hold", 32'h8000_0100);
    ifu_rsp_valid_i = 1'b1; ifu_rsp_instr_i = ADDI; if_ready_i = 1'b0;
    #1;
    check("hold0.if_valid", 32'(if_valid_o), 32'd1);
    next_cycle();
    clear_inputs();
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      check("hold.if_valid", 32'(if_valid_o), 32'd1);
      check("hold.if_pc", if_pc_o, 32'h8000_0100);
      check("hold.if_instr", if_instr_o, ADDI);
      check("hold.req_valid", 32'(ifu_req_valid_o), 32'd0);
      check("hold.pred", 32'(if_pred_taken_o), 32'd0);
      next_cycle();
    end
    if_ready_i = 1'b1;
    #1;
    check("hold_acc.if_valid", 32'(if_valid_o), 32'd1);
    next_cycle();
    clear_inputs();

    // Flush one cycle after the request was accepted: next response dropped
    fetch("drop", 32'h8000_0104);
    ex_flush_i = 1'b1; ex_flush_pc_i = 32'h8000_0200;
    #1;
    check("drop_flush.if_valid", 32'(if_valid_o), 32'd0);
    next_cycle();
    clear_inputs();
    ifu_rsp_valid_i = 1'b1; ifu_rsp_instr_i = NOP; if_ready_i = 1'b1;
    #1;
    check("drop_rsp.if_valid", 32'(if_valid_o), 32'd0);
    check("drop_rsp.req_valid", 32'(ifu_req_valid_o), 32'd0);
    next_cycle();
    clear_inputs();

    // Flush in the same cycle as the request handshake
    #1;
    check("hs_flush.addr", ifu_req_addr_o, 32'h8000_0200);
    ifu_req_ready_i = 1'b1; ex_flush_i = 1'b1; ex_flush_pc_i = 32'h8000_0300;
    next_cycle();
    clear_inputs();
    ifu_rsp_valid_i = 1'b1; ifu_rsp_instr_i = NOP; if_ready_i = 1'b1;
    #1;
    check("hs_flush_rsp.if_valid", 32'(if_valid_o), 32'd0);
    next_cycle();
    clear_inputs();

    // Flush in the same cycle as the response: no drop flag afterwards
    fetch("rsp_flush", 32'h8000_0300);
    ifu_rsp_valid_i = 1'b1; ifu_rsp_instr_i = NOP; if_ready_i = 1'b1;
    ex_flush_i = 1'b1; ex_flush_pc_i = 32'h8000_0400;
    #1;
    check("rsp_flush.if_valid", 32'(if_valid_o), 32'd0);
    next_cycle();
    clear_inputs();
    fetch("after_flush", 32'h8000_0400);
    respond("after_flush", NOP, 0, 0, 0, 0, 0, 32'h8000_0400, 0);

    // Reset with a fetch outstanding; a late response in REQ is ignored
    fetch("midrst", 32'h8000_0404);
    rst_n = 1'b0;
    #1;
    check("midrst.req_valid", 32'(ifu_req_valid_o), 32'd0);
    check("midrst.addr", ifu_req_addr_o, 32'h8000_0000);
    next_cycle();
    #2 rst_n = 1'b1;
    #1;
    check("midrst_rel.req_valid", 32'(ifu_req_valid_o), 32'd1);
    ifu_rsp_valid_i = 1'b1; ifu_rsp_instr_i = NOP; if_ready_i = 1'b1;
    #1;
    check("late_rsp.if_valid", 32'(if_valid_o), 32'd0);
    next_cycle();
    clear_inputs();
    fetch("restart", 32'h8000_0000);
    respond("restart", NOP, 0, 0, 0, 0, 0, 32'h8000_0000, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_pc_gen.md
IF_PC_GEN -- requirements
Module: if_pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, single clock; all state rising-edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port ifu_req_valid_o, output, 1, fetch request valid.
REQ-005 SHALL have port ifu_req_ready_i, input, 1, memory accepts request.
REQ-006 SHALL have port ifu_req_addr_o, output, `XLEN, fetch address.
REQ-007 SHALL have port ifu_rsp_valid_i, input, 1, instruction return valid.
REQ-008 SHALL have port ifu_rsp_instr_i, input, `INSTR_WIDTH, returned instruction.
REQ-009 SHALL have port mini_instr_o, output, `INSTR_WIDTH, instruction driven to IF mini-decoder (combinational from rsp or hold register).
REQ-010 SHALL have ports mini_dec_jal_i, mini_dec_jalr_i, mini_dec_branch_i, input, 1 each, mini-decoder class flags.
REQ-011 SHALL have ports mini_dec_rs1_idx_i (5) and mini_dec_imm_i (`XLEN), input, mini-decoder rs1 index and sign-extended immediate.
REQ-012 SHALL have ports if_valid_o (1), if_ready_i (1), if_pc_o (`XLEN), if_instr_o (`INSTR_WIDTH), if_pred_taken_o (1), output/input as named, IF-to-ID handshake.
REQ-013 SHALL have ports ex_flush_i (1) and ex_flush_pc_i (`XLEN), input, EX redirect.

Function
REQ-014 SHALL keep at most one outstanding fetch; states REQ, RSP, HOLD, JWAIT.
REQ-015 REQ: ifu_req_valid_o=1, addr=pc; on ifu_req_ready_i -> RSP.
REQ-016 RSP: on ifu_rsp_valid_i, instruction presented to ID same cycle (if_valid_o=1, if_pc_o=pc).
REQ-017 Next PC: jal -> pc+imm, pred_taken=1; branch with imm[31]=1 (backward) -> pc+imm, pred_taken=1; branch forward -> pc+4, pred_taken=0; jalr with rs1==0 -> imm & ~1, pred_taken=1; otherwise pc+4, pred_taken=0; all modulo 2^XLEN.
REQ-018 Accepted (if_ready_i=1) non-jalr or jalr-x0 -> pc<=next PC, state REQ.
REQ-019 Accepted jalr with rs1!=0 -> state JWAIT, pred_taken=0, no fetch until ex_flush_i.
REQ-020 Not accepted -> latch instr/pc into hold register, state HOLD; HOLD keeps if_valid_o=1 with stable pc/instr/pred_taken until accepted, then REQ-018/019 apply.
REQ-021 ex_flush_i has priority over everything: pc<=ex_flush_pc_i, if_valid_o=0 that cycle, state REQ next cycle (or RSP-drop, REQ-022).
REQ-022 Flush while request accepted but response pending: set drop flag; the next ifu_rsp_valid_i is discarded (not presented), then state REQ with flush PC.
REQ-023 Flush in same cycle as ifu_req_ready_i handshake: that request becomes outstanding-and-dropped per REQ-022.
REQ-024 Flush in same cycle as rsp valid: response discarded, no drop flag set.
REQ-025 if_valid_o SHALL never assert in REQ or JWAIT.

Reset
REQ-026 While rst_n=0: pc=RESET_PC, state REQ, drop flag 0, hold register 0, ifu_req_valid_o=0, if_valid_o=0, if_pred_taken_o=0.
REQ-027 First cycle after deassert: ifu_req_valid_o=1, ifu_req_addr_o=RESET_PC.
REQ-028 Reset mid-operation SHALL abandon any outstanding fetch; a late response after reset SHALL be ignored only if it arrives in state REQ (memory side also reset).

Verification
REQ-029 Reset, ready=1, rsp nop (0x00000013) each cycle -> addresses 0x80000000, 0x80000004, 0x80000008; pred_taken=0.
REQ-030 At pc 0x80000010 return jal imm=-16 -> if_pred_taken_o=1, next fetch addr 0x80000000.
REQ-031 Branch imm=+8 at 0x80000000 -> next 0x80000004, pred=0; branch imm=-4 -> next 0x7FFFFFFC, pred=1.
REQ-032 jalr rs1=5 -> no ifu_req_valid_o until ex_flush_i with pc 0x80000100; next request addr 0x80000100.
REQ-033 if_ready_i=0 for 3 cycles on rsp -> if_valid_o held, pc/instr stable, no new request.
REQ-034 Flush to 0x80000200 one cycle after request accepted -> following response dropped, next request addr 0x80000200.
